preg_free_list: RTL and testbench
=================================

// Module: preg_free_list
// PURPOSE
//  Physical-register allocator for the rename stage. A circular FIFO of free preg ids
//  replaces the linear counter allocator. It grants one preg per cycle to rename and
//  takes back one preg per cycle from retire. It supports out-of-order free order and
//  re-initialises the whole list on a pipeline flush.
// PARAMETERS
//  PRFSIZE       64   number of physical registers (power of 2)
//  PREG_ID_BITS  6    $clog2(PRFSIZE); width of a preg id
//  INIT_RSVD     0    pregs 0..INIT_RSVD-1 are never placed in the list at init
// PORTS
//  clk            in   1               clock
//  rstn           in   1               reset: synchronous, active-low
//  alloc_req_i    in   1               rename wants a preg this cycle
//  alloc_ready_o  out  1               a preg is available (count>0 and state RUN)
//  alloc_preg_o   out  PREG_ID_BITS    preg granted (valid when alloc_ready_o)
//  free_valid_i   in   1               retire returns a preg
//  free_preg_i    in   PREG_ID_BITS    preg being returned
//  flush_i        in   1               pipeline flush: rebuild the full free list
//  count_o        out  PREG_ID_BITS+1  number of free pregs held
//  init_done_o    out  1               1 while state RUN
//  error_o        out  1               1-cycle pulse on illegal free (overflow or during INIT)
// BEHAVIOUR
//  - Storage: fifo[PRFSIZE] of PREG_ID_BITS.
//  - Pointers: head_q/tail_q, PREG_ID_BITS wide, wrap naturally mod PRFSIZE.
//  - Count: count_q, PREG_ID_BITS+1 wide. N = PRFSIZE-INIT_RSVD.
//  - Reset (rstn=0 at posedge): state<=INIT, init_cnt<=0, head<=0, tail<=0, count<=0,
//    error<=0. So alloc_ready_o=0, init_done_o=0, count_o=0.
//    Reset overrides flush and all requests, including mid-INIT or mid-RUN.
//  - INIT state: each cycle fifo[init_cnt] <= init_cnt+INIT_RSVD, init_cnt++.
//    - After N writes: state<=RUN, head=0, tail=N mod PRFSIZE, count=N.
//    - INIT lasts exactly N cycles after reset or flush is released.
//    - alloc_ready_o=0 throughout.
//    - free_valid_i in INIT is dropped and pulses error_o.
//  - RUN state:
//    - alloc_ready_o = (count_q!=0).
//    - alloc_preg_o = fifo[head_q], combinational read.
//    - alloc fire = alloc_req_i && alloc_ready_o; on fire, head++.
//    - free fire = free_valid_i && count_q!=PRFSIZE; on fire, fifo[tail]<=free_preg_i,
//      tail++.
//    - count_d = count_q + free_fire - alloc_fire. Simultaneous alloc+free leaves count
//      unchanged.
//    - Free while count==PRFSIZE: dropped, error_o=1 next cycle, nothing changes.
//    - No same-cycle bypass: a preg freed at cycle t is allocatable from t+1 at the
//      earliest. With count==0, a free at t raises alloc_ready_o at t+1.
//    - Allocation order is strict FIFO order of frees. Duplicate-free detection is not
//      in scope.
//  - flush_i=1 (any state): next state INIT, init_cnt<=0, count<=0, pointers<=0.
//    Alloc/free presented in the flush cycle are discarded: no pointer update, no error.
//    Flush during INIT restarts INIT.
//  - alloc_req_i when alloc_ready_o=0 has no effect. Rename must hold the instruction
//    (stall).
//  - All outputs except alloc_preg_o are registered or derived from registered state
//    only. No combinational path from any input to alloc_ready_o.
// TESTING
//  1 Reset then idle: alloc_ready_o=0 for exactly 64 cycles. Then count_o=64,
//    init_done_o=1, alloc_preg_o=0.
//  2 Alloc every cycle from RUN: grants 0,1,..,63 on consecutive cycles. Then
//    alloc_ready_o=0, count_o=0.
//  3 Empty list, free preg 5 at cycle t: alloc_ready_o=1 and alloc_preg_o=5 at t+1,
//    count_o=1.
//  4 count=10, alloc+free(42) same cycle: count stays 10. After draining the other
//    entries, 42 is granted.
//  5 Full list (64), free(7): error_o=1 for one cycle, count_o stays 64, order unchanged.
//    Free during INIT also gives error_o=1.
//  6 Alloc 40, free 40 in order 39..0, alloc 64 (pointer wrap): grants 40..63 then 39..0.
//    Flush mid-sequence then gives 64-cycle INIT and order 0..63.

Source files
------------

// File: rtl/preg_free_list.sv
// Purpose : circular free list of physical register ids for the rename stage.
// Latency : grant is a combinational read of the list head; a returned preg is grantable one cycle later.
// Backpress: alloc_ready_o low (empty or rebuilding) stalls rename; a free into a full list is dropped and flagged.
//
// Ports
//   clk, rstn      clock, synchronous active-low reset
//   alloc_req_i    rename consumes the granted preg this cycle (only when alloc_ready_o)
//   alloc_ready_o  a preg is available (list non-empty and not rebuilding)
//   alloc_preg_o   preg id at the head of the list
//   free_valid_i   retire returns free_preg_i to the tail of the list
//   flush_i        discard the list and rebuild it from scratch
//   count_o        number of free pregs currently held
//   init_done_o    high while the list is usable
//   error_o        one-cycle pulse after a dropped free (list full, or during rebuild)
module preg_free_list #(
  parameter int PRFSIZE      = 64,
  parameter int PREG_ID_BITS = $clog2(PRFSIZE),
  parameter int INIT_RSVD    = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    alloc_req_i,
  output logic                    alloc_ready_o,
  output logic [PREG_ID_BITS-1:0] alloc_preg_o,
  input  logic                    free_valid_i,
  input  logic [PREG_ID_BITS-1:0] free_preg_i,
  input  logic                    flush_i,
  output logic [PREG_ID_BITS:0]   count_o,
  output logic                    init_done_o,
  output logic                    error_o
);

  // Count and rebuild index need one extra bit so "full" (PRFSIZE) is representable.
  localparam int CW    = PREG_ID_BITS + 1;
  localparam int NFREE = PRFSIZE - INIT_RSVD;

  localparam logic [CW-1:0]           CNT_FULL  = CW'(PRFSIZE);
  localparam logic [CW-1:0]           CNT_INIT  = CW'(NFREE);
  localparam logic [CW-1:0]           INIT_LAST = CW'(NFREE - 1);
  localparam logic [PREG_ID_BITS-1:0] RSVD_ID   = PREG_ID_BITS'(INIT_RSVD);
  // Truncation gives NFREE mod PRFSIZE because PRFSIZE is a power of two.
  localparam logic [PREG_ID_BITS-1:0] TAIL_INIT = PREG_ID_BITS'(NFREE);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]           init_cnt_q;
  logic [PREG_ID_BITS-1:0] head_q;
  logic [PREG_ID_BITS-1:0] tail_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic                    error_q;

  logic [PREG_ID_BITS-1:0] fifo [PRFSIZE];

  logic in_init;
  logic in_run;
  logic init_last;
  logic list_full;
  logic list_ready;
  logic alloc_fire;
  logic free_fire;
  logic free_err;
  logic [PREG_ID_BITS-1:0] init_val;

  // ---------------------------------------------------------------------------
  // Qualified events. A flush cycle swallows every request, including the error.
  // ---------------------------------------------------------------------------
  assign in_init    = (state_q == ST_INIT);
  assign in_run     = (state_q == ST_RUN);
  assign init_last  = in_init && (init_cnt_q == INIT_LAST);
  assign list_full  = (count_q == CNT_FULL);
  assign list_ready = in_run && (count_q != '0);

  assign alloc_fire = alloc_req_i && list_ready && !flush_i;
  // A free into a full list is refused even if an alloc frees a slot the same cycle.
  assign free_fire  = free_valid_i && in_run && !list_full && !flush_i;
  assign free_err   = free_valid_i && !flush_i && (in_init || list_full);

  assign init_val   = init_cnt_q[PREG_ID_BITS-1:0] + RSVD_ID;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: if (init_last) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_INIT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Only alloc_preg_o is a memory read; the rest come from flops,
  // so there is no input-to-alloc_ready_o path.
  // ---------------------------------------------------------------------------
  always_comb begin
    alloc_ready_o = list_ready;
    init_done_o   = in_run;
    count_o       = count_q;
    error_o       = error_q;
    alloc_preg_o  = fifo[head_q];
  end

  // ---------------------------------------------------------------------------
  // Occupancy update: a simultaneous alloc and free cancel out.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    case ({free_fire, alloc_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, rebuild index and error pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      init_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else if (flush_i) begin
      init_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= free_err;
      if (in_init) begin
        init_cnt_q <= init_cnt_q + CW'(1);
        // Publish the rebuilt list in one step on the last write so that
        // count stays zero (and nothing is grantable) for the whole rebuild.
        if (init_last) begin
          head_q  <= '0;
          tail_q  <= TAIL_INIT;
          count_q <= CNT_INIT;
        end
      end else begin
        if (alloc_fire) head_q <= head_q + PREG_ID_BITS'(1);
        if (free_fire)  tail_q <= tail_q + PREG_ID_BITS'(1);
        count_q <= count_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // List storage. Not reset: every entry is rewritten by the rebuild before it
  // can be granted. Write port is shared between rebuild and retire frees.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn && !flush_i) begin
      if (in_init) begin
        fifo[init_cnt_q[PREG_ID_BITS-1:0]] <= init_val;
      end else if (free_fire) begin
        fifo[tail_q] <= free_preg_i;
      end
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Purpose : exercise preg_free_list against a queue-based model of the free list.
// Latency : one model update per clock; outputs compared 1ns after each rising edge.
// Backpress: directed stalls (empty, full, rebuild) plus a long randomized phase.
module tb_preg_free_list;

  localparam int PRF = 64;
  localparam int NB  = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alloc_req_i;
  logic          alloc_ready_o;
  logic [NB-1:0] alloc_preg_o;
  logic          free_valid_i;
  logic [NB-1:0] free_preg_i;
  logic          flush_i;
  logic [NB:0]   count_o;
  logic          init_done_o;
  logic          error_o;

  preg_free_list #(.PRFSIZE(PRF), .PREG_ID_BITS(NB), .INIT_RSVD(0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .alloc_req_i  (alloc_req_i),
    .alloc_ready_o(alloc_ready_o),
    .alloc_preg_o (alloc_preg_o),
    .free_valid_i (free_valid_i),
    .free_preg_i  (free_preg_i),
    .flush_i      (flush_i),
    .count_o      (count_o),
    .init_done_o  (init_done_o),
    .error_o      (error_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: the free list is a plain queue, rebuild is a countdown.
  int mq[$];
  bit m_run;
  int m_init_left;
  bit m_err;
  bit m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_run       = 1'b0;
    m_init_left = PRF;
    m_err       = 1'b0;
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = m_run && (mq.size() != 0);
    chk("ready",     32'(alloc_ready_o), 32'(rdy));
    chk("init_done", 32'(init_done_o),   32'(m_run));
    chk("count",     32'(count_o),       m_run ? 32'(mq.size()) : 32'd0);
    chk("error",     32'(error_o),       32'(m_err));
    if (rdy) chk("grant", 32'(alloc_preg_o), 32'(mq[0]));
  endtask

  // One clock: drive, compare current outputs with the model, clock, advance model.
  task automatic cycle(input bit a, input bit f, input int fp, input bit fl, input bit rs);
    alloc_req_i  = a;
    free_valid_i = f;
    free_preg_i  = NB'(fp);
    flush_i      = fl;
    rstn         = !rs;
    if (m_valid) check_outputs();
    @(posedge clk);
    #1;
    if (rs || fl) begin
      model_clear();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (!m_run) begin
        m_err = f;
        m_init_left--;
        if (m_init_left == 0) begin
          m_run = 1'b1;
          for (int i = 0; i < PRF; i++) mq.push_back(i);
        end
      end else begin
        int sz;
        sz    = mq.size();
        m_err = f && (sz == PRF);
        if (a && sz > 0) void'(mq.pop_front());
        if (f && sz < PRF) mq.push_back(fp % PRF);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    alloc_req_i  = 1'b0;
    free_valid_i = 1'b0;
    free_preg_i  = '0;
    flush_i      = 1'b0;
    rstn         = 1'b0;

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Rebuild after reset: exactly PRF cycles without a grant.
    for (int i = 0; i < PRF; i++) begin
      chk("t1_not_ready", 32'(alloc_ready_o), 32'd0);
      cycle(0, 0, 0, 0, 0);
    end
    chk("t1_count", 32'(count_o),      32'd64);
    chk("t1_done",  32'(init_done_o),  32'd1);
    chk("t1_ready", 32'(alloc_ready_o), 32'd1);
    chk("t1_preg",  32'(alloc_preg_o), 32'd0);

    // Drain in order 0..63.
    for (int i = 0; i < PRF; i++) begin
      chk("t2_grant", 32'(alloc_preg_o), 32'(i));
      cycle(1, 0, 0, 0, 0);
    end
    chk("t2_empty_ready", 32'(alloc_ready_o), 32'd0);
    chk("t2_empty_count", 32'(count_o),       32'd0);
    cycle(1, 0, 0, 0, 0);  // request while empty: no effect
    chk("t2_stall_count", 32'(count_o), 32'd0);

    // Free into an empty list becomes grantable next cycle.
    cycle(0, 1, 5, 0, 0);
    chk("t3_ready", 32'(alloc_ready_o), 32'd1);
    chk("t3_preg",  32'(alloc_preg_o),  32'd5);
    chk("t3_count", 32'(count_o),       32'd1);

    // count 10, then simultaneous alloc + free(42).
    for (int i = 10; i < 19; i++) cycle(0, 1, i, 0, 0);
    chk("t4_count10", 32'(count_o), 32'd10);
    cycle(1, 1, 42, 0, 0);
    chk("t4_count_same", 32'(count_o), 32'd10);
    for (int i = 10; i < 19; i++) begin
      chk("t4_drain", 32'(alloc_preg_o), 32'(i));
      cycle(1, 0, 0, 0, 0);
    end
    chk("t4_grant42", 32'(alloc_preg_o), 32'd42);
    cycle(1, 0, 0, 0, 0);
    chk("t4_empty", 32'(count_o), 32'd0);

    // Overflow when full.
    cycle(0, 0, 0, 1, 0);
    idle(PRF);
    chk("t5_full", 32'(count_o), 32'd64);
    cycle(0, 1, 7, 0, 0);
    chk("t5_err",   32'(error_o),      32'd1);
    chk("t5_count", 32'(count_o),      32'd64);
    chk("t5_order", 32'(alloc_preg_o), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("t5_err_pulse", 32'(error_o), 32'd0);

    // Free in a flush cycle is silent; free during rebuild is an error.
    cycle(0, 1, 3, 1, 0);
    chk("t5_flush_noerr", 32'(error_o), 32'd0);
    cycle(0, 1, 3, 0, 0);
    chk("t5_init_err",  32'(error_o),     32'd1);
    chk("t5_init_busy", 32'(init_done_o), 32'd0);
    idle(PRF - 1);
    chk("t5_rebuilt", 32'(count_o), 32'd64);

    // Out-of-order return and pointer wrap.
    for (int i = 0; i < 40; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 39; i >= 0; i--) cycle(0, 1, i, 0, 0);
    chk("t6_count", 32'(count_o), 32'd64);
    for (int k = 0; k < 24; k++) begin
      chk("t6_hi", 32'(alloc_preg_o), 32'(40 + k));
      cycle(1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 40; k++) begin
      chk("t6_lo", 32'(alloc_preg_o), 32'(39 - k));
      cycle(1, 0, 0, 0, 0);
    end
    chk("t6_empty", 32'(count_o), 32'd0);

    // Flush mid-sequence with alloc/free also presented.
    for (int i = 20; i < 30; i++) cycle(0, 1, i, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 9, 1, 0);
    for (int i = 0; i < PRF; i++) begin
      chk("t6_flush_not_ready", 32'(alloc_ready_o), 32'd0);
      cycle(1, 0, 0, 0, 0);
    end
    for (int i = 0; i < PRF; i++) begin
      chk("t6_reorder", 32'(alloc_preg_o), 32'(i));
      cycle(1, 0, 0, 0, 0);
    end

    // Reset in the middle of activity overrides flush and requests.
    cycle(1, 1, 11, 1, 1);
    chk("t7_rst_count", 32'(count_o),     32'd0);
    chk("t7_rst_done",  32'(init_done_o), 32'd0);

    // Randomized phases: alloc-heavy, then free-heavy, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 1200; i++) begin
        bit a, f, fl, rs;
        int fp;
        a  = ($urandom_range(0, 9) < (ph == 0 ? 7 : (ph == 1 ? 3 : 5)));
        f  = ($urandom_range(0, 9) < (ph == 0 ? 3 : (ph == 1 ? 7 : 5)));
        fp = $urandom_range(0, PRF - 1);
        fl = ($urandom_range(0, 299) == 0);
        rs = ($urandom_range(0, 799) == 0);
        cycle(a, f, fp, fl, rs);
      end
    end
    cycle(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
